iir_stream_filter: RTL

Parametrised first-order IIR filter for the oscilloscope sample path, processing one captured frame of `DEPTH` samples per `start` command. Supports bypass, low-pass and high-pass modes with a runtime coefficient. Uses valid/ready streaming on both sides at one sample per cycle, with saturating signed arithmetic. Sits between the capture buffer read-out and the display/trace memory.

---
 rtl/iir_stream_filter_if.sv | 28 ++
 rtl/iir_stream_filter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iir_stream_filter_if.sv
// Streaming bundle for iir_stream_filter: one valid/ready input stream and one
// valid/ready output stream with a frame-last qualifier.
//   in_valid/in_ready/in_data     : sample stream into the filter
//   out_valid/out_ready/out_data  : filtered stream out of the filter
//   out_last                      : marks the final sample of a frame
// Modports: master = stream source/sink (bench or neighbouring blocks),
//           slave  = the filter itself.
interface iir_stream_filter_if #(
  parameter int unsigned DATA_W = 12
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/iir_stream_filter.sv
// First-order IIR filter over one frame of DEPTH samples per start command.
// Modes: 00/11 bypass, 01 low-pass, 10 high-pass; alpha = coef / 2^COEF_W.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : frame start pulse, honoured only when idle
//   mode, coef    : filter mode and alpha numerator, latched on accepted start
//   bus           : input/output sample streams (see iir_stream_filter_if)
//   busy          : frame in progress (RUN or DRAIN)
//   frame_done    : one-cycle pulse after the last output handshake
module iir_stream_filter #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COEF_W-1:0]  coef,
  iir_stream_filter_if.slave bus,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW   = DATA_W + COEF_W + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic signed [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               mode_q;
  logic [COEF_W-1:0]        coef_q;
  logic [IdxW-1:0]          idx_q;
  logic signed [DATA_W-1:0] y_prev_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_last_q;
  logic                     frame_done_q;

  logic in_ready;
  logic accept;
  logic out_hs;

  logic signed [DATA_W:0]   d;
  logic signed [PW-1:0]     d_ext;
  logic signed [PW-1:0]     coef_ext;
  logic signed [PW-1:0]     p;
  logic signed [PW-1:0]     y_ext;
  logic signed [DATA_W-1:0] y_lp;
  logic signed [DATA_W:0]   hp;
  logic signed [DATA_W-1:0] hp_sat;
  logic signed [DATA_W-1:0] y_out;

  assign accept = bus.in_valid && in_ready;
  assign out_hs = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign frame_done    = frame_done_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && (idx_q == LastIdx)) state_d = StDrain;
      StDrain: if (out_hs && out_last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state_q == StRun) || (state_q == StDrain);
    in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
  end

  // Filter arithmetic
  always_comb begin
    d        = {bus.in_data[DATA_W-1], bus.in_data} - {y_prev_q[DATA_W-1], y_prev_q};
    d_ext    = {{(PW-DATA_W-1){d[DATA_W]}}, d};
    coef_ext = {{(PW-COEF_W){1'b0}}, coef_q};
    p        = d_ext * coef_ext;
    y_ext    = {{(PW-DATA_W){y_prev_q[DATA_W-1]}}, y_prev_q};
    // First sample seeds the recurrence; afterwards y_lp lies between y_prev and x,
    // so truncating back to DATA_W bits is exact.
    if (idx_q == '0) begin
      y_lp = bus.in_data;
    end else begin
      y_lp = DATA_W'(y_ext + (p >>> COEF_W));
    end

    hp = {bus.in_data[DATA_W-1], bus.in_data} - {y_lp[DATA_W-1], y_lp};
    if (hp[DATA_W] != hp[DATA_W-1]) begin
      hp_sat = hp[DATA_W] ? SatMin : SatMax;
    end else begin
      hp_sat = hp[DATA_W-1:0];
    end

    unique case (mode_q)
      2'b01:   y_out = y_lp;
      2'b10:   y_out = hp_sat;
      default: y_out = bus.in_data;
    endcase
  end

  // Frame control, recurrence state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= 2'b00;
      coef_q       <= '0;
      idx_q        <= '0;
      y_prev_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == StDrain) && out_hs && out_last_q;

      if ((state_q == StIdle) && start) begin
        mode_q <= mode;
        coef_q <= coef;
        idx_q  <= '0;
      end

      if (accept) begin
        y_prev_q <= y_lp;
        if (idx_q != LastIdx) idx_q <= idx_q + IdxW'(1);
      end

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= y_out;
        out_last_q  <= (idx_q == LastIdx);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule
